// File: rtl/counter_pkg.sv
// Shared types and limits for the general-purpose up/down counter.
// Imported by the counter core and the top level.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 32;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: steps the count once within 0..max_val
// and reports boundary and out-of-range conditions.
module counter_next
    import counter_pkg::*;
#(
    parameter int        WIDTH = 3,
    parameter cnt_mode_t MODE  = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] next_q,
    output logic             bnd_up,
    output logic             bnd_dn,
    output logic             oor
);

    logic at_top;
    logic at_bot;

    assign oor    = q > max_val;
    assign at_top = q == max_val;
    assign at_bot = q == '0;

    // Boundaries are tested before stepping, so q +/- 1 never truncates.
    assign bnd_up = up && at_top && !oor;
    assign bnd_dn = !up && at_bot && !oor;

    always_comb begin
        next_q = q;
        if (oor) begin
            next_q = (MODE == CNT_WRAP) ? '0 : max_val;
        end else if (up) begin
            if (at_top) begin
                next_q = (MODE == CNT_WRAP) ? '0 : q;
            end else begin
                next_q = q + WIDTH'(1);
            end
        end else begin
            if (at_bot) begin
                next_q = (MODE == CNT_WRAP) ? max_val : q;
            end else begin
                next_q = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Programmable-range up/down counter with load, wrap/saturate mode,
// registered boundary pulse and sticky overflow/underflow flags.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int        WIDTH = 3,
    parameter cnt_mode_t MODE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
        $error("updown_counter_mod: WIDTH %0d outside legal range", WIDTH);
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] step_q;
    logic             bnd_up;
    logic             bnd_dn;
    logic             oor;
    logic             step;

    counter_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .q       (cnt_q),
        .up      (up),
        .max_val (max_val),
        .next_q  (step_q),
        .bnd_up  (bnd_up),
        .bnd_dn  (bnd_dn),
        .oor     (oor)
    );

    // Load outranks counting; a load never produces a boundary event.
    assign step = en && !load;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            cnt_d = step_q;
        end
        tc_d  = step && !oor && (bnd_up || bnd_dn);
        // A set event in the clearing cycle wins.
        ovf_d = (ovf_q && !clr_flags) || (step && bnd_up);
        unf_d = (unf_q && !clr_flags) || (step && bnd_dn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign q      = cnt_q;
    assign tc     = tc_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = cnt_q == max_val;
    assign at_min = cnt_q == '0;

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter. It counts over a programmable range 0..max_val, with a selectable wrap or saturate mode, parallel load, count enable, and boundary pulse outputs. It also keeps sticky overflow and underflow flags. It is the general-purpose counter for the design, used wherever fixed-width up/down counters were previously hand-instantiated. Its output feeds timers, pointer logic and status registers.

## Interface
- WIDTH, 3: counter width in bits; legal 2..32.
- MODE, CNT_WRAP: boundary behaviour, CNT_WRAP or CNT_SAT (from counter_pkg).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  count enable; one step per cycle when high.
- up  in  1  direction; 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- max_val  in  WIDTH  inclusive upper bound of the range; quasi-static.
- clr_flags  in  1  clears the sticky ovf and unf flags.
- q  out  WIDTH  current count (registered).
- tc  out  1  registered one-cycle boundary pulse.
- ovf  out  1  sticky flag, set by an up step taken at max_val.
- unf  out  1  sticky flag, set by a down step taken at 0.
- at_max  out  1  combinational, q == max_val.
- at_min  out  1  combinational, q == 0.

## Operation
- Priority per cycle: rst > load > en. With en low and no load, q holds.
- Reset:
  - q = 0, tc = 0, ovf = 0, unf = 0.
  - at_min = 1; at_max = 1 only if max_val == 0.
- Load:
  - q <= min(load_val, max_val).
  - A load never asserts tc, ovf or unf, even if the loaded value is a boundary.
- Up step, q < max_val: q <= q + 1.
- Up step, q == max_val:
  - CNT_WRAP: q <= 0.
  - CNT_SAT: q holds.
  - Both modes: tc pulses and ovf sets.
- Down step, q > 0: q <= q - 1.
- Down step, q == 0:
  - CNT_WRAP: q <= max_val.
  - CNT_SAT: q holds.
  - Both modes: tc pulses and unf sets.
- Out-of-range state (max_val lowered below q):
  - The next enabled step forces q <= 0 (CNT_WRAP) or q <= max_val (CNT_SAT).
  - No tc, ovf or unf is raised. at_max stays 0 until this correction.
- max_val == 0:
  - q stays 0.
  - Every enabled step is a boundary event: up sets ovf, down sets unf, tc pulses each step.
- Flags:
  - clr_flags clears ovf and unf on the next edge.
  - A set event in the same cycle as clr_flags wins: the flag ends set.
- Arithmetic:
  - Computed at WIDTH bits. WIDTH-bit truncation never occurs, because boundaries are detected against max_val before stepping.
  - When max_val = 2^WIDTH-1, CNT_WRAP behaves as a plain modular counter.

## Timing
- q, tc, ovf and unf update one cycle after the inputs are sampled; latency 1.
- tc is high for exactly the one cycle that follows a boundary step. Consecutive boundary steps (CNT_SAT held at max with en high) give a continuous high tc.
- at_max and at_min are zero-latency decodes of the registered q and the live max_val.
- rst asserted mid-count takes effect at the next edge regardless of load or en. tc asserted in that cycle drops to 0.
- Inputs are synchronous to clk. max_val changes must be held stable at least one cycle before a step.

## Structure
- Package counter_pkg holds:
  - cnt_mode_t enum: CNT_WRAP = 0, CNT_SAT = 1.
  - The WIDTH legality bounds, used by an elaboration-time assertion.
- Sub-module counter_next (combinational):
  - Inputs: q, up, max_val, MODE.
  - Outputs: next_q, bnd_up, bnd_dn, oor (q > max_val).
- The top level registers next_q, tc and the flags, and applies the load and reset priority.

## Test plan
- Reset and wrap up: WIDTH=3, CNT_WRAP, max_val=7, rst then en=1, up=1 for 9 cycles.
  - q runs 0..7, 0, 1.
  - tc high only in the cycle after 7→0; ovf=1.
- Programmable range down: max_val=4, q=0, en=1, up=0.
  - q: 4, 3, 2, 1, 0, 4.
  - tc pulses after each 0→4; unf=1.
- Saturate: CNT_SAT, max_val=5, load_val=5 with load, then 3 up steps.
  - q holds 5; tc high for 3 cycles; ovf=1.
  - A following down step gives q=4.
- Load clamp and priority: max_val=3, load=1, load_val=6, en=1 in the same cycle.
  - q=3; no tc, ovf or unf.
- Flag race: a boundary step in the same cycle as clr_flags leaves ovf=1. clr_flags alone on the next cycle gives ovf=0.
- Reset mid-operation and max_val shrink:
  - rst during counting gives q=0 and tc=0 next cycle.
  - With q=6, setting max_val=2 and taking one up step gives q=0 (WRAP) or q=2 (SAT), with no tc.
